// File: rtl/cavlc_block_sequencer.sv
// Top-level CAVLC residual block controller: sequences coeff_token, trailing-one signs, levels, total_zeros, run_before.
// Optional per-stage watchdog: define CAVLC_SEQ_WATCHDOG_EN.
module cavlc_block_sequencer #(
    parameter int MAX_COEFF      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [4:0]  MaxNumCoeff,
    input  logic [15:0] BitstreamShifted,
    output logic        CtEnable,
    output logic        LvEnable,
    output logic        TzEnable,
    output logic        RbEnable,
    input  logic        CtDone,
    input  logic        LvDone,
    input  logic        TzDone,
    input  logic        RbDone,
    input  logic [4:0]  CtTotalCoeff,
    input  logic [1:0]  CtTrailingOnes,
    input  logic [3:0]  TzTotalZeros,
    input  logic [4:0]  CtNumShift,
    input  logic [4:0]  LvNumShift,
    input  logic [4:0]  TzNumShift,
    input  logic [4:0]  RbNumShift,
    input  logic        LvShiftEn,
    output logic [4:0]  NumShift,
    output logic        ShiftEn,
    output logic [4:0]  TotalCoeff,
    output logic [1:0]  TrailingOnes,
    output logic [12:0] T1Level,
    output logic        T1WrReq,
    output logic        Busy,
    output logic        BlockDone,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE, S_CT, S_T1, S_LV, S_TZ, S_RB, S_DONE, S_ERR
    } state_t;

    localparam logic [4:0] MAX_C = 5'(MAX_COEFF);

    state_t      state_q, state_d;
    logic [4:0]  max_coeff_q;
    logic [4:0]  total_coeff_q;
    logic [1:0]  trailing_ones_q;
    logic [1:0]  t1_cnt_q;
    logic        ct_en_q, lv_en_q, tz_en_q, rb_en_q;
    logic        block_done_q;
    logic        error_q;
    logic        start_acc;
    logic        t1_last;
    state_t      tz_next;

    // Only the sign bit of the shifter window is consumed here.
    logic unused_bits;
    assign unused_bits = ^BitstreamShifted[14:0];

    assign start_acc = Start && (state_q == S_IDLE);
    assign t1_last   = (t1_cnt_q == trailing_ones_q - 2'd1);
    assign tz_next   = (total_coeff_q == max_coeff_q) ? S_DONE : S_TZ;

`ifdef CAVLC_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt_q;
    logic           wd_stage;
    assign wd_stage = (state_q == S_CT) || (state_q == S_LV) ||
                      (state_q == S_TZ) || (state_q == S_RB);
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (Start) state_d = S_CT;
            S_CT: begin
                if (CtDone) begin
                    if ((CtTotalCoeff > max_coeff_q) || ({3'b000, CtTrailingOnes} > CtTotalCoeff))
                        state_d = S_ERR;
                    else if (CtTotalCoeff == 5'd0)
                        state_d = S_DONE;
                    else if (CtTrailingOnes != 2'd0)
                        state_d = S_T1;
                    else
                        state_d = S_LV;
                end
            end
            S_T1: begin
                if (t1_last)
                    state_d = (total_coeff_q > {3'b000, trailing_ones_q}) ? S_LV : tz_next;
            end
            S_LV:   if (LvDone) state_d = tz_next;
            S_TZ:   if (TzDone) state_d = (TzTotalZeros == 4'd0) ? S_DONE : S_RB;
            S_RB:   if (RbDone) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef CAVLC_SEQ_WATCHDOG_EN
        // A Done on the expiry cycle still wins, since it already moved state_d away.
        if (wd_stage && (state_d == state_q) && (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1)))
            state_d = S_ERR;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= S_IDLE;
            max_coeff_q     <= 5'd0;
            total_coeff_q   <= 5'd0;
            trailing_ones_q <= 2'd0;
            t1_cnt_q        <= 2'd0;
            ct_en_q         <= 1'b0;
            lv_en_q         <= 1'b0;
            tz_en_q         <= 1'b0;
            rb_en_q         <= 1'b0;
            block_done_q    <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ct_en_q      <= (state_d == S_CT);
            lv_en_q      <= (state_d == S_LV);
            tz_en_q      <= (state_d == S_TZ);
            rb_en_q      <= (state_d == S_RB);
            block_done_q <= (state_d == S_DONE);
            t1_cnt_q     <= ((state_q == S_T1) && (state_d == S_T1)) ? t1_cnt_q + 2'd1 : 2'd0;
            if (start_acc)
                max_coeff_q <= (MaxNumCoeff > MAX_C) ? MAX_C : MaxNumCoeff;
            if ((state_q == S_CT) && CtDone) begin
                total_coeff_q   <= CtTotalCoeff;
                trailing_ones_q <= CtTrailingOnes;
            end
            if (start_acc)
                error_q <= 1'b0;
            else if (state_d == S_ERR)
                error_q <= 1'b1;
        end
    end

`ifdef CAVLC_SEQ_WATCHDOG_EN
    always_ff @(posedge Clk) begin
        if (Reset || (state_d != state_q))
            wd_cnt_q <= '0;
        else if (wd_stage)
            wd_cnt_q <= wd_cnt_q + 1'b1;
    end
`endif

    always_comb begin
        NumShift = 5'd0;
        ShiftEn  = 1'b0;
        T1WrReq  = 1'b0;
        T1Level  = 13'd0;
        case (state_q)
            S_CT: begin
                NumShift = CtNumShift;
                ShiftEn  = 1'b1;
            end
            S_T1: begin
                NumShift = 5'd1;
                ShiftEn  = 1'b1;
                T1WrReq  = 1'b1;
                T1Level  = BitstreamShifted[15] ? 13'h1FFF : 13'h0001;
            end
            S_LV: begin
                NumShift = LvNumShift;
                ShiftEn  = LvShiftEn;
            end
            S_TZ: begin
                NumShift = TzNumShift;
                ShiftEn  = 1'b1;
            end
            S_RB: begin
                NumShift = RbNumShift;
                ShiftEn  = 1'b1;
            end
            default: ;
        endcase
    end

    assign CtEnable     = ct_en_q;
    assign LvEnable     = lv_en_q;
    assign TzEnable     = tz_en_q;
    assign RbEnable     = rb_en_q;
    assign TotalCoeff   = total_coeff_q;
    assign TrailingOnes = trailing_ones_q;
    assign Busy         = (state_q != S_IDLE);
    assign BlockDone    = block_done_q;
    assign Error        = error_q;

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// Directed bench for cavlc_block_sequencer; checks at #1 after each rising edge.
module tb_cavlc_block_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Start;
    logic [4:0]  MaxNumCoeff;
    logic [15:0] BitstreamShifted;
    logic        CtEnable, LvEnable, TzEnable, RbEnable;
    logic        CtDone, LvDone, TzDone, RbDone;
    logic [4:0]  CtTotalCoeff;
    logic [1:0]  CtTrailingOnes;
    logic [3:0]  TzTotalZeros;
    logic [4:0]  CtNumShift, LvNumShift, TzNumShift, RbNumShift;
    logic        LvShiftEn;
    logic [4:0]  NumShift;
    logic        ShiftEn;
    logic [4:0]  TotalCoeff;
    logic [1:0]  TrailingOnes;
    logic [12:0] T1Level;
    logic        T1WrReq, Busy, BlockDone, Error;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    cavlc_block_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MaxNumCoeff(MaxNumCoeff),
        .BitstreamShifted(BitstreamShifted),
        .CtEnable(CtEnable), .LvEnable(LvEnable), .TzEnable(TzEnable), .RbEnable(RbEnable),
        .CtDone(CtDone), .LvDone(LvDone), .TzDone(TzDone), .RbDone(RbDone),
        .CtTotalCoeff(CtTotalCoeff), .CtTrailingOnes(CtTrailingOnes), .TzTotalZeros(TzTotalZeros),
        .CtNumShift(CtNumShift), .LvNumShift(LvNumShift), .TzNumShift(TzNumShift), .RbNumShift(RbNumShift),
        .LvShiftEn(LvShiftEn), .NumShift(NumShift), .ShiftEn(ShiftEn),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .T1Level(T1Level), .T1WrReq(T1WrReq),
        .Busy(Busy), .BlockDone(BlockDone), .Error(Error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_block(input logic [4:0] maxc);
        MaxNumCoeff = maxc;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic ct_done(input logic [4:0] tc, input logic [1:0] t1);
        CtTotalCoeff   = tc;
        CtTrailingOnes = t1;
        CtDone = 1'b1;
        tick();
        CtDone = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; MaxNumCoeff = 5'd16; BitstreamShifted = 16'h0;
        CtDone = 1'b0; LvDone = 1'b0; TzDone = 1'b0; RbDone = 1'b0;
        CtTotalCoeff = 5'd0; CtTrailingOnes = 2'd0; TzTotalZeros = 4'd0;
        CtNumShift = 5'd5; LvNumShift = 5'd7; TzNumShift = 5'd3; RbNumShift = 5'd2;
        LvShiftEn = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_outs", {CtEnable, LvEnable, TzEnable, RbEnable, ShiftEn, T1WrReq, BlockDone, Error}, 32'd0);
        chk("rst_latched", {TotalCoeff, TrailingOnes, T1Level}, 32'd0);
        Reset = 1'b0;

        // TotalCoeff = 0: CT -> DONE
        start_block(5'd16);
        chk("t0_ct_en", {CtEnable, LvEnable, TzEnable, RbEnable, Busy}, 32'b10001);
        chk("t0_ct_shift", {ShiftEn, NumShift}, {1'b1, 5'd5});
        ct_done(5'd0, 2'd0);
        chk("t0_done", {BlockDone, CtEnable, LvEnable, TzEnable, Busy}, 32'b10001);
        tick();
        chk("t0_idle", {BlockDone, Busy, ShiftEn}, 32'd0);

        // TC=3 T1=2: T1 x2 -> LV -> TZ -> RB -> DONE
        start_block(5'd16);
        BitstreamShifted = 16'h8000;
        ct_done(5'd3, 2'd2);
        chk("t1_latch", {TotalCoeff, TrailingOnes}, {5'd3, 2'd2});
        chk("t1_c0", {T1WrReq, T1Level, ShiftEn, NumShift}, {1'b1, 13'h1FFF, 1'b1, 5'd1});
        tick();
        BitstreamShifted = 16'h0000;
        #1;
        chk("t1_c1", {T1WrReq, T1Level, ShiftEn, NumShift}, {1'b1, 13'h0001, 1'b1, 5'd1});
        tick();
        chk("t1_lv", {T1WrReq, LvEnable, CtEnable}, 32'b010);
        LvShiftEn = 1'b1;
        #1;
        chk("t1_lv_shift", {ShiftEn, NumShift}, {1'b1, 5'd7});
        LvShiftEn = 1'b0;
        #1;
        chk("t1_lv_noshift", 32'(ShiftEn), 32'd0);
        TzDone = 1'b1;  // wrong state: ignored
        tick();
        TzDone = 1'b0;
        chk("t1_lv_hold", {LvEnable, TzEnable}, 32'b10);
        LvDone = 1'b1; tick(); LvDone = 1'b0;
        chk("t1_tz", {LvEnable, TzEnable, ShiftEn, NumShift}, {1'b0, 1'b1, 1'b1, 5'd3});
        TzTotalZeros = 4'd2; TzDone = 1'b1; tick(); TzDone = 1'b0;
        chk("t1_rb", {TzEnable, RbEnable, NumShift}, {1'b0, 1'b1, 5'd2});
        RbDone = 1'b1; tick(); RbDone = 1'b0;
        chk("t1_done", {RbEnable, BlockDone}, 32'b01);
        tick();

        // TC=16 T1=3 Max=16: T1 x3 -> LV -> DONE
        start_block(5'd16);
        BitstreamShifted = 16'hFFFF;
        ct_done(5'd16, 2'd3);
        for (int i = 0; i < 3; i++) begin
            chk("full_t1", {T1WrReq, T1Level}, {1'b1, 13'h1FFF});
            tick();
        end
        chk("full_lv", {T1WrReq, LvEnable}, 32'b01);
        LvDone = 1'b1; tick(); LvDone = 1'b0;
        chk("full_done", {BlockDone, TzEnable, RbEnable}, 32'b100);
        tick();

        // TC=2 T1=2 TotalZeros=0: T1 x2 -> TZ -> DONE
        start_block(5'd16);
        BitstreamShifted = 16'h0000;
        ct_done(5'd2, 2'd2);
        chk("t1only_c0", {T1WrReq, T1Level}, {1'b1, 13'h0001});
        tick();
        chk("t1only_c1", 32'(T1WrReq), 32'd1);
        tick();
        chk("t1only_tz", {T1WrReq, LvEnable, TzEnable}, 32'b001);
        TzTotalZeros = 4'd0; TzDone = 1'b1; tick(); TzDone = 1'b0;
        chk("t1only_done", {BlockDone, RbEnable}, 32'b10);
        tick();

        // Max=4, TC=5 -> ERR; Error sticky until next Start
        start_block(5'd4);
        ct_done(5'd5, 2'd0);
        chk("err_state", {Error, Busy, BlockDone}, 32'b110);
        tick();
        chk("err_idle", {Error, Busy}, 32'b10);
        tick();
        chk("err_sticky", 32'(Error), 32'd1);
        start_block(5'd16);
        chk("err_clear", {Error, CtEnable}, 32'b01);
        // Trailing ones > TotalCoeff -> ERR
        ct_done(5'd1, 2'd2);
        chk("err_t1", {Error, Busy}, 32'b11);
        tick();

        // Reset during LV; Start ignored while busy
        start_block(5'd16);
        ct_done(5'd2, 2'd0);
        chk("lv_direct", {T1WrReq, LvEnable}, 32'b01);
        Start = 1'b1; tick(); Start = 1'b0;
        chk("busy_start", {LvEnable, CtEnable}, 32'b10);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("rst_mid", {LvEnable, Busy, ShiftEn}, 32'd0);
        Reset = 1'b1; Start = 1'b1; tick(); Reset = 1'b0; Start = 1'b0;
        chk("rst_vs_start", {Busy, CtEnable}, 32'd0);

        // LV held without LvDone
        start_block(5'd16);
        ct_done(5'd1, 2'd0);
        for (int i = 0; i < 63; i++) tick();
        chk("wd_pre", {LvEnable, Error}, 32'b10);
        tick();
`ifdef CAVLC_SEQ_WATCHDOG_EN
        chk("wd_err", {LvEnable, Error, Busy}, 32'b011);
        tick();
        chk("wd_idle", {Busy, Error}, 32'b01);
`else
        chk("hold_lv", {LvEnable, Error}, 32'b10);
        for (int i = 0; i < 40; i++) tick();
        chk("hold_lv_long", {LvEnable, Busy}, 32'b11);
        Reset = 1'b1; tick(); Reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
